// File: rtl/wb_pkg.sv
// wb_pkg: shared load encodings and writeback state type
package wb_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {EMPTY, WRITE, WAIT_LOAD} wb_state_e;
endpackage

// File: rtl/load_extract.sv
// load_extract: selects and sign/zero-extends the addressed byte/half of a load word
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    value = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
            funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
            funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
            funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} :
            word;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage; waits for loads, writes the register file, counts retirements
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [4:0]               rd_address_in,
  input  logic [XLEN-1:0]          result_in,
  input  logic                     is_load_in,
  input  logic [2:0]               load_funct3_in,
  input  logic [1:0]               load_offset_in,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  output logic [4:0]               rd_address,
  output logic [XLEN-1:0]          rd_data,
  output logic                     retire_valid,
  output logic [INSTRET_WIDTH-1:0] instret
);
  wb_state_e       state;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic [XLEN-1:0] load_value;

  load_extract #(.XLEN(XLEN)) u_extract (
    .funct3(funct3_q),
    .offset(offset_q),
    .word  (mem_rsp_data),
    .value (load_value)
  );

  assign ready_in = state != WAIT_LOAD;

  // Outputs are registered as the next state's values, so rd_address/rd_data are zero outside WRITE
  // and rd = 0 forces rd_data to zero as well.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMPTY;
      rd_q         <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      rd_address   <= '0;
      rd_data      <= '0;
      retire_valid <= 1'b0;
      instret      <= '0;
    end else begin
      if (retire_valid) instret <= instret + INSTRET_WIDTH'(1);
      if (state == WAIT_LOAD) begin
        if (mem_rsp_valid) begin
          state        <= WRITE;
          rd_address   <= rd_q;
          rd_data      <= rd_q == 5'd0 ? '0 : load_value;
          retire_valid <= 1'b1;
        end
      end else if (valid_in && is_load_in) begin
        state        <= WAIT_LOAD;
        rd_q         <= rd_address_in;
        funct3_q     <= load_funct3_in;
        offset_q     <= load_offset_in;
        rd_address   <= '0;
        rd_data      <= '0;
        retire_valid <= 1'b0;
      end else if (valid_in) begin
        state        <= WRITE;
        rd_address   <= rd_address_in;
        rd_data      <= rd_address_in == 5'd0 ? '0 : result_in;
        retire_valid <= 1'b1;
      end else begin
        state        <= EMPTY;
        rd_address   <= '0;
        rd_data      <= '0;
        retire_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Accepts completed instructions from the memory stage and waits for outstanding load responses.
- Sign- or zero-extends load data, then drives the register file write port (rd_address/rd_data).
- Keeps the retired-instruction counter.
- The register file forwards rd_data combinationally to decode, so this block drives rd_address = 0 in every cycle where no write is intended.

Parameters:
- XLEN, 32, datapath width.
- INSTRET_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  memory stage presents an instruction
- ready_in  out  1  stage can accept; transfer when valid_in && ready_in
- rd_address_in  in  5  destination register
- result_in  in  XLEN  ALU/CSR/link result (ignored for loads)
- is_load_in  in  1  instruction is a load awaiting a memory response
- load_funct3_in  in  3  load type (RISC-V funct3)
- load_offset_in  in  2  byte address low bits of the load
- mem_rsp_valid  in  1  load response data valid this cycle
- mem_rsp_data  in  XLEN  aligned 32-bit word from data memory
- rd_address  out  5  register file write address; 0 = no write
- rd_data  out  XLEN  register file write data
- retire_valid  out  1  one-cycle pulse per retired instruction
- instret  out  INSTRET_WIDTH  count of retired instructions

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- Reset values: state EMPTY, rd_address 0, rd_data 0, retire_valid 0, instret 0, internal rd/data registers 0. ready_in = 1 while in reset (ready_in = state != WAIT_LOAD).
- States: EMPTY, WRITE, WAIT_LOAD.
- EMPTY (ready_in = 1):
  - Transfer of a non-load: latch rd/result, go to WRITE.
  - Transfer of a load: latch rd/funct3/offset, go to WAIT_LOAD.
  - Otherwise stay in EMPTY.
- WRITE:
  - Outputs: rd_address = latched rd, rd_data = latched data, retire_valid = 1, ready_in = 1.
  - The register file commits at the end of this cycle.
  - A same-cycle transfer goes to WRITE (non-load) or WAIT_LOAD (load); with no transfer, go to EMPTY.
  - Sustained throughput for non-loads: 1 instruction per cycle.
- WAIT_LOAD (ready_in = 0, rd_address = 0, retire_valid = 0):
  - On mem_rsp_valid, register the extracted data and go to WRITE.
  - Otherwise wait indefinitely; there is no timeout.
- Latency:
  - Non-load accepted at edge E0 is written at E1.
  - Load accepted at E0 with response in the cycle after E0 is written at E2.
- Outside WRITE, rd_address = 0 and rd_data = 0.
- Instruction with rd = 0 still retires (retire_valid = 1, instret increments); rd_address = 0, so no write occurs and rd_data = 0.
- mem_rsp_valid in EMPTY or WRITE is ignored; no data is captured.
- Load extraction (combinational, applied to mem_rsp_data):
  - 000 LB: byte lane selected by offset[1:0], sign-extended.
  - 100 LBU: same lane, zero-extended.
  - 001 LH: half selected by offset[1], sign-extended; offset[0] ignored.
  - 101 LHU: same half, zero-extended.
  - 010 LW, and encodings 011/110/111: full word.
- instret increments by 1 on each retire_valid cycle and wraps from all-ones to 0.
- Reset mid-load aborts the load: nothing is written, nothing is retired, and a late response after reset release is ignored.
- No combinational path from valid_in or mem_rsp_* to rd_address/rd_data. ready_in depends only on state.

Decomposition:
- Shared package wb_pkg:
  - funct3 constants LB/LH/LW/LBU/LHU.
  - State enum {EMPTY, WRITE, WAIT_LOAD}.
- One sub-module: load_extract (purely combinational; funct3, offset, word -> extended XLEN value), reused later by the memory stage for misalignment checks.

Test Plan:
- Reset then idle 5 cycles -> ready_in = 1, rd_address = 0, rd_data = 0, instret = 0, retire_valid never asserts.
- Back-to-back non-loads x5 = 0x11, x6 = 0x22, x0 = 0x33 on consecutive cycles -> writes (5, 0x11) then (6, 0x22) on successive cycles, third cycle rd_address = 0 with retire_valid = 1; instret = 3.
- Load LB x7, offset 3, response 0x80FFFFFF delayed 4 cycles:
  - ready_in low and rd_address = 0 during the wait.
  - Write (7, 0xFFFFFF80) one cycle after the response.
- Loads on word 0x8001C0DE, checking all five extraction modes:
  - LBU off 1 -> 0xC0.
  - LH off 2 -> 0xFFFF8001.
  - LHU off 3 -> 0x00008001.
  - LW off 0 -> 0x8001C0DE.
  - LB off 0 -> 0xFFFFFFDE.
- Spurious mem_rsp_valid while EMPTY, then a load whose response arrives later -> the spurious data is never written; only the later response value is written.
- Assert reset_n mid-WAIT_LOAD, release, then drive mem_rsp_valid -> no write, no retire, instret = 0; preload instret to all-ones via force, retire one instruction -> instret = 0.
